// File: rtl/window_pkg.sv
// Shared constants for the Hamming window and inverse-window stages.
// Coefficients live here so both ends of the link use identical values.
package window_pkg;

    localparam int SIZE   = 8;
    localparam int WIDTH  = 8;
    localparam int PWIDTH = 16;
    localparam int CWIDTH = 8;
    localparam int IWIDTH = $clog2(SIZE);

    localparam logic [CWIDTH-1:0] COEF [SIZE] = '{
        8'd8, 8'd21, 8'd54, 8'd86, 8'd100, 8'd86, 8'd54, 8'd21
    };

    localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    function automatic logic [WIDTH-1:0] saturate(
        input logic [PWIDTH-1:0] q
    );
        if (q > PWIDTH'(SAT_MAX))
            return SAT_MAX;
        return q[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// done and quotient are valid in the cycle the last bit is resolved.
module serial_divider
    import window_pkg::*;
#(
    parameter int DW = PWIDTH,
    parameter int VW = CWIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0] dq;
    logic [VW-1:0] rem;
    logic [VW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic [VW:0]   trial;
    logic          qbit;
    logic [VW-1:0] rem_nxt;

    // rem < dvs always holds, so a non-subtracting step fits in VW bits
    always_comb begin
        trial   = {rem, dq[DW-1]} - {1'b0, dvs};
        qbit    = ~trial[VW];
        rem_nxt = qbit ? trial[VW-1:0] : {rem[VW-2:0], dq[DW-1]};
    end

    assign done     = busy && (cnt == '0);
    assign quotient = {dq[DW-2:0], qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            dq   <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            dq   <= dividend;
            dvs  <= divisor;
            rem  <= '0;
            cnt  <= CW'(DW - 1);
            busy <= 1'b1;
        end else if (busy) begin
            dq  <= {dq[DW-2:0], qbit};
            rem <= rem_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/inverse_window.sv
// Divides each windowed product by its Hamming coefficient, one
// position at a time through a shared serial divider.
module inverse_window
    import window_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE*PWIDTH-1:0]  windowed_function,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SIZE*WIDTH-1:0]   restored_function,
    output logic                    out_valid,
    input  logic                    out_ready
);

    state_t              state;
    logic [PWIDTH-1:0]   frame [SIZE];
    logic [IWIDTH-1:0]   idx;

    logic                div_start;
    logic                div_busy;
    logic                div_done;
    logic [PWIDTH-1:0]   div_quotient;

    assign div_start = (state == LOAD) && !div_busy;

    serial_divider #(
        .DW (PWIDTH),
        .VW (CWIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (frame[idx]),
        .divisor  (COEF[idx]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            restored_function <= '0;
            idx               <= '0;
            for (int j = 0; j < SIZE; j++)
                frame[j] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < SIZE; j++)
                            frame[j] <= windowed_function[j*PWIDTH +: PWIDTH];
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    state <= DIV;
                end
                DIV: begin
                    if (div_done) begin
                        restored_function[idx*WIDTH +: WIDTH]
                            <= saturate(div_quotient);
                        if (idx == IWIDTH'(SIZE - 1)) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_window.sv
// Directed and randomised checks for inverse_window.
// Expected samples come from the bench's own coefficient table.
module tb_inverse_window;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] wf;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  rf;
    logic         out_valid;
    logic         out_ready;

    int n_err = 0;
    int n_chk = 0;
    int coef [8] = '{8, 21, 54, 86, 100, 86, 54, 21};

    inverse_window dut (
        .clk               (clk),
        .rst               (rst),
        .windowed_function (wf),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .restored_function (rf),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] window(input logic [63:0] s,
                                            input bit rnd);
        logic [127:0] f;
        int p;
        f = '0;
        for (int j = 0; j < 8; j++) begin
            p = int'(s[j*8 +: 8]) * coef[j];
            if (rnd)
                p += int'($urandom_range(0, coef[j] - 1));
            f[j*16 +: 16] = 16'(p);
        end
        return f;
    endfunction

    task automatic send(input logic [127:0] f);
        @(negedge clk);
        check("acc_ready", 64'(in_ready), 64'd1);
        wf       = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 400);
        if (!out_valid)
            check("timeout", 64'd0, 64'd1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rel_valid", 64'(out_valid), 64'd0);
        check("rel_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0]  orig;
        logic [63:0]  exp_sat;
        logic [127:0] f;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wf        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", rf, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("idle_ready", 64'(in_ready), 64'd1);
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_data", rf, 64'd0);

        // round trip, exact products
        orig = 64'hFF3C_32C8_281E_140A;
        send(window(orig, 1'b0));
        wait_done(n);
        check("rt_latency", 64'(n), 64'd136);
        check("rt_data", rf, orig);
        release_out();
        check("rt_hold", rf, orig);

        // saturation, truncation, zero
        f = '0;
        f[0*16 +: 16] = 16'd17;
        f[1*16 +: 16] = 16'd0;
        f[2*16 +: 16] = 16'd215;
        f[3*16 +: 16] = 16'd22016;
        f[4*16 +: 16] = 16'hFFFF;
        f[5*16 +: 16] = 16'd22015;
        f[6*16 +: 16] = 16'd1;
        f[7*16 +: 16] = 16'd5355;
        exp_sat = 64'hFF00_FFFF_FF03_0002;
        send(f);
        wait_done(n);
        check("sat_latency", 64'(n), 64'd136);
        check("sat_data", rf, exp_sat);

        // backpressure with an ignored frame offered in DONE
        @(negedge clk);
        wf       = window(64'h0102_0304_0506_0708, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", rf, exp_sat);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_rel_valid", 64'(out_valid), 64'd0);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        check("bp_rel_data", rf, exp_sat);
        orig = 64'h0A14_1E28_C832_3CFF;
        @(negedge clk);
        wf = window(orig, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accept", 64'(in_ready), 64'd0);
        wait_done(n);
        check("b2b_latency", 64'(n), 64'd136);
        check("b2b_data", rf, orig);
        release_out();

        // mid-frame reset
        send(window(64'h1122_3344_5566_7788, 1'b1));
        repeat (59) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data", rf, 64'd0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            check("mr_no_valid", 64'(out_valid), 64'd0);
        end
        orig = 64'h8899_AABB_CCDD_EEF0;
        send(window(orig, 1'b1));
        wait_done(n);
        check("mr_next_data", rf, orig);
        release_out();

        // random frames with random stalls
        for (int k = 0; k < 200; k++) begin
            orig = {$urandom, $urandom};
            send(window(orig, 1'b1));
            wait_done(n);
            check("rnd_latency", 64'(n), 64'd136);
            check("rnd_data", rf, orig);
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk);
                #1;
                check("rnd_stall", 64'(out_valid), 64'd1);
            end
            release_out();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
